// File: rtl/hwpe_periph_cfg_sequencer.sv
// Drives write/read/poll commands as single HWPE peripheral transactions, one outstanding at a time.
// Optional poll timeout enabled by `define HWPE_PERIPH_CFG_SEQ_TIMEOUT_EN.
module hwpe_periph_cfg_sequencer #(
  parameter int unsigned ID_WIDTH  = 10,
  parameter int unsigned ID_VALUE  = 0,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned MAX_POLLS = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [31:0]         cmd_addr_i,
  input  logic [31:0]         cmd_data_i,
  input  logic [31:0]         cmd_mask_i,
  input  logic [3:0]          cmd_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_data_o,
  output logic                rsp_err_o,
  output logic                periph_req_o,
  input  logic                periph_gnt_i,
  output logic [31:0]         periph_add_o,
  output logic                periph_wen_o,
  output logic [3:0]          periph_be_o,
  output logic [31:0]         periph_data_o,
  output logic [ID_WIDTH-1:0] periph_id_o,
  input  logic                periph_r_valid_i,
  input  logic [31:0]         periph_r_data_i,
  input  logic [ID_WIDTH-1:0] periph_r_id_i,
  output logic                busy_o
);

  localparam logic [ID_WIDTH-1:0] ID_V = ID_WIDTH'(ID_VALUE);
  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT_RSP, GAP, RESP} state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [31:0]      data_q;
  logic [31:0]      mask_q;
  logic [GAP_W-1:0] gap_q;
  logic             rsp_hit, is_write, is_poll, poll_match, poll_done;

  assign rsp_hit    = periph_r_valid_i && (periph_r_id_i == ID_V);
  assign is_write   = (op_q == 2'b00);
  assign is_poll    = (op_q == 2'b10);
  assign poll_match = ((periph_r_data_i ^ data_q) & mask_q) == 32'h0;

`ifdef HWPE_PERIPH_CFG_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_POLLS + 1);
  logic [CNT_W-1:0] poll_cnt_q;
  assign poll_done = poll_match || (poll_cnt_q == CNT_W'(MAX_POLLS - 1));
`else
  logic unused_max_polls;
  assign unused_max_polls = ^MAX_POLLS;
  assign poll_done = poll_match;
  assign rsp_err_o = 1'b0;
`endif

  // clear_i wins over acceptance, so ready is masked in a clear cycle
  assign cmd_ready_o = (state_q == IDLE) && !clear_i;
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = (state_q == RESP);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear_i) begin
      state_q       <= IDLE;
      op_q          <= 2'b00;
      data_q        <= '0;
      mask_q        <= '0;
      gap_q         <= '0;
      periph_req_o  <= 1'b0;
      periph_add_o  <= '0;
      periph_wen_o  <= 1'b1;
      periph_be_o   <= '0;
      periph_data_o <= '0;
      periph_id_o   <= '0;
      rsp_data_o    <= '0;
`ifdef HWPE_PERIPH_CFG_SEQ_TIMEOUT_EN
      rsp_err_o     <= 1'b0;
      poll_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          op_q          <= cmd_op_i;
          data_q        <= cmd_data_i;
          mask_q        <= cmd_mask_i;
          periph_req_o  <= 1'b1;
          periph_add_o  <= cmd_addr_i;
          periph_wen_o  <= (cmd_op_i != 2'b00);
          periph_be_o   <= cmd_be_i;
          periph_data_o <= (cmd_op_i == 2'b00) ? cmd_data_i : 32'h0;
          periph_id_o   <= ID_V;
`ifdef HWPE_PERIPH_CFG_SEQ_TIMEOUT_EN
          poll_cnt_q    <= '0;
`endif
          state_q       <= REQ;
        end
        REQ: if (periph_gnt_i) begin
          periph_req_o <= 1'b0;
          state_q      <= WAIT_RSP;
        end
        WAIT_RSP: if (rsp_hit) begin
          rsp_data_o <= is_write ? 32'h0 : periph_r_data_i;
          if (!is_poll || poll_done) begin
`ifdef HWPE_PERIPH_CFG_SEQ_TIMEOUT_EN
            rsp_err_o <= is_poll && !poll_match;
`endif
            state_q <= RESP;
          end else begin
`ifdef HWPE_PERIPH_CFG_SEQ_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_q + 1'b1;
`endif
            if (POLL_GAP == 0) begin
              periph_req_o <= 1'b1;
              state_q      <= REQ;
            end else begin
              gap_q   <= GAP_W'(POLL_GAP - 1);
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            periph_req_o <= 1'b1;
            state_q      <= REQ;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        RESP: if (rsp_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_periph_cfg_sequencer.sv
// Directed bench for hwpe_periph_cfg_sequencer with a transaction-level model and per-cycle protocol checks.
module tb_hwpe_periph_cfg_sequencer;
  localparam int IDW = 10;
  localparam int IDV = 3;
  localparam int PGAP = 4;
  localparam int MAXP = 4;

  logic clk = 1'b0, rst_ni, clear_i;
  logic cmd_valid, cmd_ready_o;
  logic [1:0] cmd_op;
  logic [31:0] cmd_addr, cmd_data, cmd_mask;
  logic [3:0] cmd_be;
  logic rsp_valid_o, rsp_ready, rsp_err_o;
  logic [31:0] rsp_data_o;
  logic periph_req_o, periph_gnt, periph_wen_o, r_valid, busy_o;
  logic [31:0] periph_add_o, periph_data_o, r_data;
  logic [3:0] periph_be_o;
  logic [IDW-1:0] periph_id_o, r_id;

  hwpe_periph_cfg_sequencer #(.ID_WIDTH(IDW), .ID_VALUE(IDV), .POLL_GAP(PGAP), .MAX_POLLS(MAXP)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask), .cmd_be_i(cmd_be),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt), .periph_add_o(periph_add_o),
    .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
    .periph_id_o(periph_id_o), .periph_r_valid_i(r_valid), .periph_r_data_i(r_data),
    .periph_r_id_i(r_id), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  int gnt_delay = 0, wcnt = 0, pend = 0, nvals = 1, ridx = 0;
  bit bad_id = 0, force_rv = 0, pend_write = 0;
  logic [31:0] vals [8];
  int g_log[$];
  int rv_log[$];

  initial begin
    periph_gnt = 1'b0; r_valid = 1'b0; r_data = '0; r_id = '0;
    forever begin
      @(negedge clk);
      r_valid = 1'b0; r_id = IDW'(IDV); r_data = '0;
      if (pend == 2) begin
        r_valid = 1'b1; r_id = IDW'(IDV + 1); r_data = 32'hBAD0_BAD0; pend = 1;
      end else if (pend == 1) begin
        r_valid = 1'b1;
        r_data = pend_write ? 32'hFFFF_FFFF : vals[(ridx < nvals) ? ridx : nvals - 1];
        if (!pend_write) ridx++;
        rv_log.push_back(cyc);
        pend = 0;
      end else if (force_rv) begin
        r_valid = 1'b1; r_data = 32'h5555_AAAA; force_rv = 0;
      end
      periph_gnt = 1'b0;
      if (periph_req_o) begin
        if (wcnt >= gnt_delay) begin
          periph_gnt = 1'b1; wcnt = 0; pend = bad_id ? 2 : 1;
          pend_write = !periph_wen_o;
          g_log.push_back(cyc);
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
`ifdef HWPE_PERIPH_CFG_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic [31:0] exp_d_q[$];
  bit exp_e_q[$];
  logic [1:0] cur_op;
  logic [31:0] cur_addr, cur_data;
  logic [3:0] cur_be;
  bit exp_busy = 0;
  bit p_req = 0, p_gnt = 0, p_clr = 0, p_rv = 0, p_rr = 0, p_err = 0;
  logic [31:0] p_add = '0, p_rd = '0, last_d = '0;
  bit last_e = 0;
  int rsp_rise = 0, rsp_cnt = 0, last_hs = 0;

  initial forever begin
    @(negedge clk); #1;
    if (!rst_ni) exp_busy = 0;
    else begin
      chk("busy", busy_o, exp_busy);
      chk("cmd_ready", cmd_ready_o, !exp_busy && !clear_i);
      if (p_req && !p_gnt && !p_clr) begin
        chk("req_hold", periph_req_o, 1);
        chk("add_hold", periph_add_o, p_add);
      end
      if (periph_req_o) begin
        chk("req_add", periph_add_o, cur_addr);
        chk("req_wen", periph_wen_o, cur_op != 2'b00);
        chk("req_be", periph_be_o, cur_be);
        chk("req_wdata", periph_data_o, (cur_op == 2'b00) ? cur_data : 32'h0);
        chk("req_id", periph_id_o, IDV);
        chk("req_during_rsp", rsp_valid_o, 0);
      end
      if (p_rv && !p_rr && !p_clr) begin
        chk("rsp_valid_hold", rsp_valid_o, 1);
        chk("rsp_data_hold", rsp_data_o, p_rd);
        chk("rsp_err_hold", rsp_err_o, p_err);
      end
      if (rsp_valid_o && !p_rv) rsp_rise = cyc;
      if (rsp_valid_o && rsp_ready && !clear_i) begin
        if (exp_d_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          chk("rsp_data", rsp_data_o, exp_d_q.pop_front());
          chk("rsp_err", rsp_err_o, exp_e_q.pop_front());
        end
        last_d = rsp_data_o; last_e = rsp_err_o; last_hs = cyc; rsp_cnt++;
      end
      if (clear_i) exp_busy = 0;
      else if (cmd_valid && cmd_ready_o) exp_busy = 1;
      else if (rsp_valid_o && rsp_ready) exp_busy = 0;
    end
    p_req = periph_req_o; p_gnt = periph_gnt; p_clr = clear_i; p_add = periph_add_o;
    p_rv = rsp_valid_o; p_rr = rsp_ready; p_rd = rsp_data_o; p_err = rsp_err_o;
  end

  // Expected response from the slave's value list: first masked match, or timeout.
  task automatic predict(input logic [1:0] op, input logic [31:0] data, input logic [31:0] mask, output int nreq);
    logic [31:0] ed, v;
    bit ee;
    ee = 0; nreq = 1; ed = 32'h0;
    if (op == 2'b10) begin
      for (int k = 0; k < 64; k++) begin
        v = vals[(k < nvals) ? k : nvals - 1];
        nreq = k + 1; ed = v;
        if ((v & mask) == (data & mask)) break;
        if (TO_EN && nreq == MAXP) begin ee = 1; break; end
      end
    end else if (op != 2'b00) ed = vals[0];
    exp_d_q.push_back(ed);
    exp_e_q.push_back(ee);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] mask, input logic [3:0] be, output int acc);
    @(negedge clk);
    cur_op = op; cur_addr = addr; cur_data = data; cur_be = be;
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask; cmd_be = be; cmd_valid = 1'b1;
    #1;
    acc = -1;
    for (int t = 0; t < 50; t++) begin
      if (cmd_ready_o) begin acc = cyc; break; end
      @(negedge clk); #1;
    end
    chk("cmd_accepted", acc >= 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  int t_acc;
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] mask, input logic [3:0] be, input int gd, input bit bad);
    int nreq, base, gexp, glast;
    gnt_delay = gd; bad_id = bad; ridx = 0;
    g_log.delete(); rv_log.delete();
    predict(op, data, mask, nreq);
    base = rsp_cnt;
    send(op, addr, data, mask, be, t_acc);
    for (int t = 0; t < 3000 && rsp_cnt == base; t++) @(negedge clk);
    chk("rsp_done", rsp_cnt - base, 1);
    chk("n_requests", g_log.size(), nreq);
    gexp = t_acc + 1 + gd; glast = gexp;
    for (int k = 0; k < g_log.size() && k < nreq; k++) begin
      chk("grant_cycle", g_log[k], gexp);
      glast = gexp;
      gexp = gexp + 2 + int'(bad) + PGAP + gd;
    end
    chk("rsp_cycle", rsp_rise, glast + 2 + int'(bad));
  endtask

  initial begin
    int a0, a1, base;
    rst_ni = 1'b0; clear_i = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
    cmd_data = '0; cmd_mask = '0; cmd_be = '0; rsp_ready = 1'b1;
    cur_op = '0; cur_addr = '0; cur_data = '0; cur_be = '0;
    for (int i = 0; i < 8; i++) vals[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", periph_req_o, 0);   chk("rst_add", periph_add_o, 0);
    chk("rst_wen", periph_wen_o, 1);   chk("rst_be", periph_be_o, 0);
    chk("rst_wdata", periph_data_o, 0); chk("rst_id", periph_id_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0); chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);  chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    @(negedge clk); rst_ni = 1'b1;

    // write, zero-wait slave
    run_cmd(2'b00, 32'h0010_0000, 32'hDEAD_BEEF, 32'h0, 4'hF, 0, 0);
    chk("t1_req_latency", g_log[0] - t_acc, 1);
    chk("t1_rsp_latency", rsp_rise - t_acc, 3);
    chk("t1_data", last_d, 32'h0); chk("t1_err", last_e, 0);

    // read, grant after 3 waiting cycles
    vals[0] = 32'h1234_5678; nvals = 1;
    run_cmd(2'b01, 32'h0010_000C, 32'h0, 32'h0, 4'hF, 3, 0);
    chk("t2_req_cycles", g_log[0] - t_acc, 4);
    chk("t2_data", last_d, 32'h1234_5678);

    // poll bit0 == 0, slave returns 1,1,0
    vals[0] = 32'h1; vals[1] = 32'h1; vals[2] = 32'h0; nvals = 3;
    run_cmd(2'b10, 32'h0010_000C, 32'h0, 32'h1, 4'hF, 0, 0);
    chk("t3_nreq", g_log.size(), 3);
    chk("t3_retry_gap", g_log[1] - rv_log[0], 5);
    chk("t3_data", last_d, 32'h0); chk("t3_err", last_e, 0);

    // long mismatch run: times out when compiled in, otherwise retries until match
    for (int i = 0; i < 5; i++) vals[i] = 32'h1;
    vals[5] = 32'h0; nvals = 6;
    run_cmd(2'b10, 32'h0010_0008, 32'h0, 32'h1, 4'hF, 1, 0);
`ifdef HWPE_PERIPH_CFG_SEQ_TIMEOUT_EN
    chk("t4_nreq", g_log.size(), 4); chk("t4_data", last_d, 32'h1); chk("t4_err", last_e, 1);
`else
    chk("t4_nreq", g_log.size(), 6); chk("t4_data", last_d, 32'h0); chk("t4_err", last_e, 0);
`endif

    // foreign-ID response ahead of the real one
    vals[0] = 32'hCAFE_F00D; nvals = 1;
    run_cmd(2'b01, 32'h0010_0004, 32'h0, 32'h0, 4'hF, 0, 1);
    chk("t5_data", last_d, 32'hCAFE_F00D);

    // reserved op as read, rsp_ready held low 5 cycles
    vals[0] = 32'hA5A5_0F0F; nvals = 1; rsp_ready = 1'b0;
    fork
      begin
        for (int t = 0; t < 100 && !rsp_valid_o; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        rsp_ready = 1'b1;
      end
    join_none
    run_cmd(2'b11, 32'h0010_0014, 32'h0, 32'h0, 4'h3, 0, 0);
    chk("t6_hold_cycles", last_hs - rsp_rise, 5);
    chk("t6_data", last_d, 32'hA5A5_0F0F);

    // clear while the request is waiting for grant
    gnt_delay = 100;
    send(2'b01, 32'h0010_0010, 32'h0, 32'h0, 4'hF, a0);
    @(negedge clk); clear_i = 1'b1;
    @(negedge clk); clear_i = 1'b0;
    #1;
    chk("t7_req_dropped", periph_req_o, 0);
    chk("t7_busy", busy_o, 0);
    chk("t7_add_cleared", periph_add_o, 0);
    force_rv = 1'b1;
    for (int t = 0; t < 6; t++) begin @(negedge clk); #1; chk("t7_late_rvalid", rsp_valid_o, 0); end
    gnt_delay = 0;

    // masked poll after clear, matches first time
    vals[0] = 32'h0000_008F; nvals = 1;
    run_cmd(2'b10, 32'h0010_0018, 32'h0000_0080, 32'h0000_00F0, 4'hF, 0, 0);
    chk("t8_data", last_d, 32'h0000_008F);

    // back-to-back writes: accept-to-accept spacing
    predict(2'b00, 32'h0, 32'h0, a1);
    predict(2'b00, 32'h0, 32'h0, a1);
    base = rsp_cnt;
    send(2'b00, 32'h0010_0020, 32'h0000_0011, 32'h0, 4'h5, a0);
    send(2'b00, 32'h0010_0024, 32'h0000_0022, 32'h0, 4'hA, a1);
    for (int t = 0; t < 100 && rsp_cnt < base + 2; t++) @(negedge clk);
    chk("t9_both_rsp", rsp_cnt - base, 2);
    chk("t9_throughput", a1 - a0, 4);

    repeat (3) @(negedge clk);
    chk("leftover_expectations", exp_d_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hwpe_periph_cfg_sequencer.md
# hwpe_periph_cfg_sequencer

Initiator-side driver for the HWPE peripheral (configuration) port: it accepts write, read and poll commands on a valid/ready command channel and issues them as single peripheral transactions (req/gnt request phase, r_valid/r_id response phase) towards an accelerator's register-file slave such as the RedMulE control port. It sits between a controller (bench sequencer, DMA-driven boot loader or small SoC control unit) and the accelerator, replacing hand-rolled core stores for programming and job-completion polling. One transaction is outstanding at a time.

## Interface
- ID_WIDTH, 10, width of periph_id_o / periph_r_id_i
- ID_VALUE, 0, transaction ID driven on periph_id_o; only responses carrying this ID are consumed
- POLL_GAP, 4, idle cycles between consecutive poll attempts (0 allowed)
- MAX_POLLS, 1024, poll attempts before timeout (≥1; used only with timeout compiled in)

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous abort to IDLE
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_op_i  in  2  00 write, 01 read, 10 poll, 11 reserved (treated as read)
- cmd_addr_i  in  32  register address
- cmd_data_i  in  32  write data, or expected value for poll
- cmd_mask_i  in  32  poll compare mask (ignored otherwise)
- cmd_be_i  in  4  byte enables
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake
- rsp_data_o  out  32  read data / last polled value; 0 for writes
- rsp_err_o  out  1  poll timed out
- periph_req_o, periph_gnt_i  out/in  1  request handshake
- periph_add_o  out  32, periph_wen_o  out  1 (1 = read, 0 = write), periph_be_o  out  4, periph_data_o  out  32, periph_id_o  out  ID_WIDTH
- periph_r_valid_i  in  1, periph_r_data_i  in  32, periph_r_id_i  in  ID_WIDTH
- busy_o  out  1  state != IDLE

## Operation
- FSM: IDLE, REQ, WAIT_RSP, GAP, RESP.
- IDLE: cmd_ready_o=1; on cmd_valid_i latch op/addr/data/mask/be, clear poll counter → REQ.
- REQ: periph_req_o=1, address/wen/be/data/id driven from latched registers, held stable until periph_gnt_i; on gnt → WAIT_RSP. Poll/read drive wen=1, data=0.
- WAIT_RSP: wait for periph_r_valid_i with periph_r_id_i==ID_VALUE; other IDs ignored. Every granted request (read or write) yields exactly one response.
  - write/read: capture r_data (write → 0) → RESP.
  - poll: match if (r_data & mask) == (data & mask) → RESP, err=0. Otherwise increment counter; counter==MAX_POLLS → RESP, err=1; else → GAP (or directly REQ if POLL_GAP=0).
- GAP: count POLL_GAP cycles → REQ.
- RESP: rsp_valid_o=1, data/err stable until rsp_ready_i → IDLE.
- clear_i: any state → IDLE next cycle, drops periph_req_o even without gnt (abort semantics); a late r_valid in IDLE is ignored. clear_i has priority over all other transitions; cmd not accepted in a clear cycle.

## Timing
- Reset/clear values: periph_req_o=0, periph_add_o/data/be/id=0, periph_wen_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, cmd_ready_o=1 (reset only), busy_o=0.
- All outputs are from registers or decoded from state; no combinational path cmd_* → periph_* or periph_* → rsp_*.
- Latency, zero-wait slave (gnt same cycle as req, r_valid one cycle later): cmd accepted cycle 0, req cycle 1, r_valid cycle 2, rsp_valid_o cycle 3. Command-to-command throughput 4 cycles with rsp_ready_i high.
- r_valid in the same cycle as gnt is not consumed (slave contract: response ≥1 cycle after gnt).
- Poll retry spacing: r_valid mismatch cycle N → next req at N+1+POLL_GAP.

## Configuration
- HWPE_PERIPH_CFG_SEQ_TIMEOUT_EN defined: poll counter of $clog2(MAX_POLLS+1) bits, timeout as above.
- Not defined: counter removed, polls retry indefinitely, rsp_err_o tied 0, MAX_POLLS unused.

## Test plan
- Write 0xDEADBEEF to 0x00100000, be=0xF, slave grants immediately → one req cycle, wen=0, rsp at cycle 3 with data=0, err=0.
- Read 0x0010000C, gnt delayed 3 cycles, slave returns 0x12345678 → req/add stable 4 cycles, rsp_data_o=0x12345678.
- Poll addr 0x0010000C, mask 0x1, expected 0, slave returns 1,1,0, POLL_GAP=4 → exactly 3 requests spaced 5 cycles after each r_valid, rsp_data_o=0, err=0.
- Timeout on, MAX_POLLS=4, slave always returns 1 → exactly 4 requests, err=1, rsp_data_o=1.
- r_valid with r_id=ID_VALUE+1 injected during WAIT_RSP → ignored; correct-ID response completes command.
- rsp_ready_i low 5 cycles → rsp_valid/data held, cmd_ready_o=0; clear_i during REQ → periph_req_o=0 next cycle, busy_o=0, later r_valid ignored.
